// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake and control-unit signals around the program counter sequencer.
// master = pc_sequencer side, slave = control unit / instruction memory side.
interface pc_sequencer_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic            mem_req;
    logic            mem_ready;
    logic            ir_load;
    logic            exec_done;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            halt_req;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            call;
    logic            ret;
    logic            rs_error;

    modport master (
        input  start, mem_ready, exec_done, stall, branch_taken, branch_target,
               jump, jump_target, halt_req, call, ret,
        output mem_req, ir_load, pc, halted, rs_error
    );

    modport slave (
        output start, mem_ready, exec_done, stall, branch_taken, branch_target,
               jump, jump_target, halt_req, call, ret,
        input  mem_req, ir_load, pc, halted, rs_error
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and sequences IDLE/FETCH/WAIT/EXEC/HALT with registered fetch handshake.
// Define PC_RETURN_STACK_EN to add an RS_DEPTH-entry call/return stack with sticky rs_error.
module pc_sequencer #(
    parameter int              PC_W         = 10,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter int              RS_DEPTH     = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT} state_e;

    if (RS_DEPTH < 1) begin : g_bad_depth
        $error("RS_DEPTH must be at least 1");
    end

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_base;
    logic [PC_W-1:0] pc_d;
    logic            mem_req_q;
    logic            ir_load_q;
    logic            halted_q;
    logic            commit;

    assign commit = state_q == S_EXEC && !bus.stall && bus.exec_done;

`ifdef PC_RETURN_STACK_EN
    localparam int SP_W  = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = RS_DEPTH > 1 ? $clog2(RS_DEPTH) : 1;

    logic [PC_W-1:0] rs_q [RS_DEPTH];
    logic [SP_W-1:0] sp_q;
    logic            rs_error_q;
    logic            rs_push;
    logic            rs_pop;
    logic            rs_fault;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;

    always_comb begin
        pc_inc   = pc_q + 1'b1;
        pc_base  = bus.jump ? bus.jump_target : bus.branch_taken ? bus.branch_target : pc_inc;
        rs_pop   = bus.ret;
        rs_push  = !bus.ret && bus.call;
        rs_fault = (rs_pop && sp_q == '0) || (rs_push && sp_q == SP_W'(RS_DEPTH));
        top_idx  = IDX_W'(sp_q - 1'b1);
        push_idx = IDX_W'(sp_q);
        pc_d     = rs_fault ? pc_inc : rs_pop ? rs_q[top_idx] : rs_push ? bus.jump_target : pc_base;
    end

    // A faulting push/pop leaves the stack untouched; only the sticky flag records it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sp_q       <= '0;
            rs_error_q <= 1'b0;
        end else if (commit) begin
            if (rs_fault) begin
                rs_error_q <= 1'b1;
            end else if (rs_push) begin
                rs_q[push_idx] <= pc_inc;
                sp_q           <= sp_q + 1'b1;
            end else if (rs_pop) begin
                sp_q <= sp_q - 1'b1;
            end
        end
    end

    assign bus.rs_error = rs_error_q;
`else
    always_comb begin
        pc_inc  = pc_q + 1'b1;
        pc_base = bus.jump ? bus.jump_target : bus.branch_taken ? bus.branch_target : pc_inc;
        pc_d    = pc_base;
    end

    assign bus.rs_error = 1'b0;
`endif

    // mem_req is set on entry to FETCH and held through WAIT until the memory answers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_VECTOR;
            mem_req_q <= 1'b0;
            ir_load_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            ir_load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                    end
                end
                S_FETCH: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        state_q   <= S_EXEC;
                        mem_req_q <= 1'b0;
                        ir_load_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (commit) begin
                        pc_q      <= pc_d;
                        state_q   <= bus.halt_req ? S_HALT : S_FETCH;
                        mem_req_q <= !bus.halt_req;
                        halted_q  <= bus.halt_req;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc      = pc_q;
    assign bus.mem_req = mem_req_q;
    assign bus.ir_load = ir_load_q;
    assign bus.halted  = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of fetch handshake, PC update priority, wrap, stall, halt and reset.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   req_n;
    int   ld_n;

    pc_sequencer_if #(.PC_W(10)) bus ();

    pc_sequencer #(.PC_W(10)) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while in FETCH; mem_ready is raised during the rdy-th WAIT cycle.
    task automatic fetch(input int rdy, output int rq, output int ld);
        rq = 0;
        ld = 0;
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rq += int'(bus.mem_req);
            ld += int'(bus.ir_load);
            if (bus.ir_load) break;
            bus.mem_ready = (rq == rdy + 1);
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic fetch_ok(input int rdy);
        int rq;
        int ld;
        fetch(rdy, rq, ld);
        check("fetch_ir_load", ld, 1);
        check("fetch_mem_req_cycles", rq, rdy + 1);
    endtask

    task automatic ex(input logic j, input logic [9:0] jt, input logic b, input logic [9:0] bt,
                      input logic h, input logic c, input logic r);
        bus.exec_done = 1'b1;
        bus.jump = j;
        bus.jump_target = jt;
        bus.branch_taken = b;
        bus.branch_target = bt;
        bus.halt_req = h;
        bus.call = c;
        bus.ret = r;
        @(negedge clk);
        bus.exec_done = 1'b0;
        bus.jump = 1'b0;
        bus.branch_taken = 1'b0;
        bus.halt_req = 1'b0;
        bus.call = 1'b0;
        bus.ret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 0; bus.mem_ready = 0; bus.exec_done = 0; bus.stall = 0;
        bus.branch_taken = 0; bus.branch_target = '0; bus.jump = 0; bus.jump_target = '0;
        bus.halt_req = 0; bus.call = 0; bus.ret = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", bus.pc, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_ir_load", bus.ir_load, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_rs_error", bus.rs_error, 0);
        reset = 0;
        bus.start = 1;
        @(negedge clk);
        fetch(3, req_n, ld_n);
        check("t1_mem_req_cycles", req_n, 4);
        check("t1_ir_load_pulses", ld_n, 1);
        check("t1_pc_in_exec", bus.pc, 0);
        @(negedge clk);
        check("t1_ir_load_one_cycle", bus.ir_load, 0);
        check("t1_exec_mem_req", bus.mem_req, 0);
        ex(0, 0, 0, 0, 0, 0, 0);
        check("t1_pc_inc", bus.pc, 1);
        check("t1_refetch_req", bus.mem_req, 1);

        fetch_ok(1);
        ex(1, 10'h3FF, 0, 0, 0, 0, 0);
        check("wrap_preload", bus.pc, 10'h3FF);
        fetch_ok(1);
        ex(0, 0, 0, 0, 0, 0, 0);
        check("wrap_pc", bus.pc, 10'h000);

        fetch_ok(2);
        ex(1, 10'h120, 1, 10'h050, 0, 0, 0);
        check("prio_jump_wins", bus.pc, 10'h120);
        fetch_ok(1);
        bus.stall = 1;
        bus.exec_done = 1; bus.jump = 1; bus.jump_target = 10'h2AA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_pc", bus.pc, 10'h120);
            check("stall_mem_req", bus.mem_req, 0);
        end
        bus.stall = 0; bus.exec_done = 0; bus.jump = 0;
        ex(0, 0, 1, 10'h050, 0, 0, 0);
        check("branch_after_stall", bus.pc, 10'h050);

`ifndef PC_RETURN_STACK_EN
        fetch_ok(1);
        ex(0, 10'h200, 0, 0, 0, 1, 1);
        check("noret_call_ignored", bus.pc, 10'h051);
        check("noret_rs_error", bus.rs_error, 0);
`else
        fetch_ok(1);
        ex(1, 10'h010, 0, 0, 0, 0, 0);
        fetch_ok(1);
        ex(0, 10'h200, 0, 0, 0, 1, 0);
        check("call_pc", bus.pc, 10'h200);
        fetch_ok(1);
        ex(0, 0, 0, 0, 0, 0, 1);
        check("ret_pc", bus.pc, 10'h011);
        check("ret_rs_error", bus.rs_error, 0);
        for (int k = 0; k < 4; k++) begin
            fetch_ok(1);
            ex(0, 10'h100 + 10'(k * 16), 0, 0, 0, 1, 0);
            check("call_n_pc", bus.pc, 10'h100 + 10'(k * 16));
            check("call_n_rs_error", bus.rs_error, 0);
        end
        fetch_ok(1);
        ex(0, 10'h140, 0, 0, 0, 1, 0);
        check("overflow_pc", bus.pc, 10'h131);
        check("overflow_rs_error", bus.rs_error, 1);
        fetch_ok(1);
        ex(0, 0, 0, 0, 0, 0, 1);
        check("ret_after_overflow", bus.pc, 10'h121);
        check("rs_error_sticky", bus.rs_error, 1);
`endif

        fetch_ok(1);
        ex(1, 10'h007, 0, 0, 0, 0, 0);
        fetch_ok(1);
        ex(0, 0, 0, 0, 1, 0, 0);
        check("halt_pc", bus.pc, 10'h008);
        check("halt_flag", bus.halted, 1);
        check("halt_mem_req", bus.mem_req, 0);
        bus.start = 1; bus.mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_frozen_pc", bus.pc, 10'h008);
            check("halt_ignores_start", bus.mem_req, 0);
            check("halt_no_ir_load", bus.ir_load, 0);
        end
        bus.start = 0; bus.mem_ready = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("halt_reset_pc", bus.pc, 0);
        check("halt_reset_halted", bus.halted, 0);
        check("halt_reset_rs_error", bus.rs_error, 0);

        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        check("midwait_req", bus.mem_req, 1);
        reset = 1; bus.mem_ready = 1;
        @(negedge clk);
        check("midwait_req_drop", bus.mem_req, 0);
        check("midwait_no_ir_load", bus.ir_load, 0);
        reset = 0; bus.mem_ready = 0;
        @(negedge clk);
        check("midwait_idle_req", bus.mem_req, 0);
        check("midwait_idle_ir_load", bus.ir_load, 0);
        bus.start = 1;
        @(negedge clk);
        fetch_ok(1);
        ex(0, 0, 0, 0, 0, 0, 0);
        check("after_reset_pc", bus.pc, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
